unified_mem_arbiter: RTL

//  Shares one external single-port word memory between instruction fetch (IF) and data

---
 rtl/unified_mem_arbiter_pkg.sv | 20 ++
 rtl/unified_mem_arbiter_timeout.sv | 25 ++
 rtl/unified_mem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared word length, FSM state encoding and owner codes for the memory arbiter
// Contents:
//   WORD_LEN      default data word width
//   arb_state_t   2-bit FSM state encoding (IDLE, IF_BUSY, MEM_BUSY, DONE)
//   ARB_OWNER_*   which requester owns the current external access
//   is_busy()     true while an external access is outstanding
package unified_mem_arbiter_pkg;
    localparam int WORD_LEN = 32;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2,
        DONE     = 2'd3
    } arb_state_t;
    localparam logic ARB_OWNER_IF  = 1'b0;
    localparam logic ARB_OWNER_MEM = 1'b1;
    function automatic logic is_busy(arb_state_t s);
        return s == IF_BUSY || s == MEM_BUSY;
    endfunction
endpackage

// File: rtl/unified_mem_arbiter_timeout.sv
// mem_timeout_counter: watchdog that flags an external access which has been busy for TIMEOUT_CYC cycles
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   run      count this cycle (an access is outstanding)
//   clear    return the count to zero (arbiter idle)
//   expired  high during the TIMEOUT_CYC-th running cycle; constant 0 when TIMEOUT_CYC is 0
module mem_timeout_counter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk)
        if (rst || clear) cnt <= '0;
        else if (run) cnt <= cnt + 1'b1;
    // Expiry fires in the last allowed busy cycle so ext_req is high for exactly TIMEOUT_CYC cycles
    assign expired = (TIMEOUT_CYC > 0) && run && cnt == LAST;
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port word memory between instruction fetch and the MEM stage
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   if_req/if_addr/if_flush   fetch request (held until if_ack), PC, branch-taken cancel
//   if_ack/if_rdata           one-cycle fetch completion pulse and fetched word
//   mem_req_rd/mem_req_wr     load/store request (held until mem_ack)
//   mem_addr/mem_wdata        load/store address and store data
//   mem_ack/mem_rdata         one-cycle completion pulse and load data (0 for a store)
//   stall_if/stall_mem        pipeline stall requests
//   ext_req/ext_we/ext_addr/ext_wdata   registered external memory request
//   ext_ready/ext_rdata       external completion and read data
//   timeout_err               sticky watchdog flag
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int DATA_W      = WORD_LEN,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req_rd,
    input  logic              mem_req_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic              ext_ready,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              timeout_err
);
    arb_state_t state, state_n;
    logic owner, discard, discard_n, expired, busy, finish, mem_any, if_go;
    logic [DATA_W-1:0] cap_data;

    mem_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
        .clk(clk),
        .rst(rst),
        .run(busy),
        .clear(state == IDLE),
        .expired(expired)
    );

    assign mem_any   = mem_req_rd || mem_req_wr;
    assign if_go     = if_req && !if_flush;
    assign busy      = is_busy(state);
    // ready wins over a same-cycle expiry
    assign finish    = busy && (ext_ready || expired);
    // a flush arriving in the completion cycle still discards the fetch
    assign discard_n = discard || (state == IF_BUSY && if_flush);
    // timed-out accesses and stores both hand back zero
    assign cap_data  = ext_ready && !ext_we ? ext_rdata : '0;
    assign if_ack    = state == DONE && owner == ARB_OWNER_IF && !discard;
    assign mem_ack   = state == DONE && owner == ARB_OWNER_MEM;
    assign stall_if  = if_req && !if_ack && !if_flush;
    assign stall_mem = mem_any && !mem_ack;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:              state_n = mem_any ? MEM_BUSY : if_go ? IF_BUSY : IDLE;
            IF_BUSY, MEM_BUSY: state_n = finish ? DONE : state;
            default:           state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= ARB_OWNER_IF;
            discard     <= 1'b0;
            ext_req     <= 1'b0;
            ext_we      <= 1'b0;
            ext_addr    <= '0;
            ext_wdata   <= '0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state   <= state_n;
            ext_req <= is_busy(state_n);
            discard <= state == DONE ? 1'b0 : discard_n;
            if (state == IDLE && mem_any) begin
                owner     <= ARB_OWNER_MEM;
                ext_we    <= mem_req_wr;
                ext_addr  <= mem_addr;
                ext_wdata <= mem_wdata;
            end else if (state == IDLE && if_go) begin
                owner    <= ARB_OWNER_IF;
                ext_we   <= 1'b0;
                ext_addr <= if_addr;
            end
            if (finish && owner == ARB_OWNER_MEM) mem_rdata <= cap_data;
            if (finish && owner == ARB_OWNER_IF && !discard_n) if_rdata <= cap_data;
            if (busy && expired && !ext_ready) timeout_err <= 1'b1;
        end
    end

    always_ff @(posedge clk)
        if (!rst) assert (!(mem_req_rd && mem_req_wr));
endmodule
